// File: rtl/reg_dump.sv
// Debug reader for reg_file: walks a register index range through a read port
// and streams each value out on a valid/ready interface tagged with index and last-flag.
module reg_dump #(
  parameter int M = 32,
  parameter int N = 8,
  localparam int addrSz = $clog2(M)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic [addrSz-1:0] first,
  input  logic [addrSz-1:0] last,
  output logic [addrSz-1:0] rf_addr,
  input  logic [N-1:0]      rf_data,
  output logic [N-1:0]      dump_data,
  output logic [addrSz-1:0] dump_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic [addrSz:0] M_LIM = (addrSz + 1)'(M);

  state_t            state_reg;
  logic [addrSz-1:0] ptr_reg;
  logic [addrSz-1:0] end_idx_reg;
  logic              range_ok;
  logic              take_word;
  logic              final_hs;

  assign range_ok  = (first <= last) && ({1'b0, last} < M_LIM);
  assign final_hs  = (state_reg == SEND) && dump_valid && dump_ready && dump_last;
  // A new word is captured in LOAD and on every non-final handshake, so the
  // stream has no bubbles while the sink keeps accepting.
  assign take_word = (state_reg == LOAD) ||
                     ((state_reg == SEND) && dump_valid && dump_ready && !dump_last);

  assign rf_addr = (state_reg == IDLE) ? '0 : ptr_reg;
  assign busy    = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      end_idx_reg <= '0;
      dump_data   <= '0;
      dump_addr   <= '0;
      dump_valid  <= 1'b0;
      dump_last   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (take_word) begin
        dump_data  <= rf_data;
        dump_addr  <= ptr_reg;
        dump_last  <= (ptr_reg == end_idx_reg);
        dump_valid <= 1'b1;
        ptr_reg    <= ptr_reg + addrSz'(1);
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            if (range_ok) begin
              ptr_reg     <= first;
              end_idx_reg <= last;
              state_reg   <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: state_reg <= SEND;
        SEND: begin
          if (final_hs) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            done       <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump with a scoreboard of expected words; a second
// instance with M=20 covers rejection of last>=M.
module tb_reg_dump;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_reset, start, dump_ready;
  logic [4:0] first, last, rf_addr, dump_addr;
  logic [7:0] rf_data, dump_data;
  logic       dump_valid, dump_last, busy, done, err;
  logic [7:0] regs [32];

  assign rf_data = regs[rf_addr];

  reg_dump #(.M(32), .N(8)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .first(first), .last(last),
    .rf_addr(rf_addr), .rf_data(rf_data), .dump_data(dump_data),
    .dump_addr(dump_addr), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_last(dump_last), .busy(busy), .done(done), .err(err)
  );

  logic       s_start;
  logic [4:0] s_first, s_last, s_rf_addr, s_dump_addr;
  logic [7:0] s_dump_data;
  logic       s_dump_valid, s_dump_last, s_busy, s_done, s_err;

  reg_dump #(.M(20), .N(8)) dut_small (
    .clk(clk), .n_reset(n_reset), .start(s_start), .first(s_first), .last(s_last),
    .rf_addr(s_rf_addr), .rf_data(8'h00), .dump_data(s_dump_data),
    .dump_addr(s_dump_addr), .dump_valid(s_dump_valid), .dump_ready(1'b1),
    .dump_last(s_dump_last), .busy(s_busy), .done(s_done), .err(s_err)
  );

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    logic       l;
  } word_t;

  word_t sb [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_hs     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set when step is called; it scores any handshake due at
  // the coming edge, advances one clock and checks the pulse/stall behaviour.
  task automatic step();
    word_t      w;
    logic       acc, rej, hs, fin, stall, hl;
    logic [7:0] hd;
    logic [4:0] ha, f0;
    acc   = n_reset && start && !busy && (first <= last);
    rej   = n_reset && start && !busy && (first > last);
    hs    = n_reset && dump_valid && dump_ready;
    fin   = hs && dump_last;
    stall = n_reset && dump_valid && !dump_ready;
    hd = dump_data; ha = dump_addr; hl = dump_last; f0 = first;
    if (hs) begin
      n_hs++;
      $display("xfer idx=%0d data=0x%02h last=%0b", ha, hd, hl);
      n_checks++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_extra_word observed=idx %0d expected=no word", ha);
      end
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check("word_addr", 32'(ha), 32'(w.a));
        check("word_data", 32'(hd), 32'(w.d));
        check("word_last", 32'(hl), 32'(w.l));
      end
    end
    if (acc) begin
      for (int i = int'(f0); i <= int'(last); i++) begin
        w.a = 5'(i);
        w.d = regs[i];
        w.l = (i == int'(last));
        sb.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    if (n_reset) begin
      check("done_pulse", 32'(done), 32'(fin));
      check("err_pulse", 32'(err), 32'(rej));
      if (acc) begin
        check("load_busy", 32'(busy), 32'd1);
        check("load_valid", 32'(dump_valid), 32'd0);
        check("load_rf_addr", 32'(rf_addr), 32'(f0));
      end
      if (stall) begin
        check("stall_valid", 32'(dump_valid), 32'd1);
        check("stall_data", 32'(dump_data), 32'(hd));
        check("stall_addr", 32'(dump_addr), 32'(ha));
        check("stall_last", 32'(dump_last), 32'(hl));
      end
    end
  endtask

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    first = f;
    last  = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int maxc, input logic [15:0] pat, input int plen,
                                output int cycles);
    int c;
    c = 0;
    while (!done && c < maxc) begin
      dump_ready = (c < plen) ? pat[c] : 1'b1;
      step();
      c++;
    end
    cycles = c;
    check("done_seen", 32'(done), 32'd1);
    check("busy_with_done", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
    check({tag, "_data"}, 32'(dump_data), 32'd0);
    check({tag, "_addr"}, 32'(dump_addr), 32'd0);
    check({tag, "_valid"}, 32'(dump_valid), 32'd0);
    check({tag, "_last"}, 32'(dump_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int cyc;
    int h0;
    int c;
    regs[0] = 8'h00;
    for (int i = 1; i < 32; i++) regs[i] = 8'($urandom_range(1, 255));
    regs[1] = 8'h11; regs[2] = 8'h22; regs[3] = 8'h33;
    n_reset = 1'b0; start = 1'b0; first = '0; last = '0; dump_ready = 1'b0;
    s_start = 1'b0; s_first = '0; s_last = '0;
    step();
    step();
    check_all_zero("reset");
    n_reset = 1'b1;
    step();

    // Range 1..3 at full rate: R+1 cycles from the start edge to done.
    dump_ready = 1'b1;
    do_start(5'd1, 5'd3);
    run_until_done(10, 16'h0000, 0, cyc);
    check("r1_cycles", 32'(cyc), 32'd4);

    // Same range with the sink stalling.
    h0 = n_hs;
    dump_ready = 1'b1;
    do_start(5'd1, 5'd3);
    run_until_done(20, 16'b0000_0000_0010_1001, 6, cyc);
    check("stall_hs_count", 32'(n_hs - h0), 32'd3);

    // Single word at index 0.
    dump_ready = 1'b1;
    do_start(5'd0, 5'd0);
    run_until_done(5, 16'h0000, 0, cyc);
    check("single_cycles", 32'(cyc), 32'd2);

    // Reversed range is rejected.
    do_start(5'd5, 5'd2);
    check("rev_busy", 32'(busy), 32'd0);
    check("rev_valid", 32'(dump_valid), 32'd0);
    step();

    // last >= M on the M=20 instance.
    s_first = 5'd3; s_last = 5'd25; s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("small_err", 32'(s_err), 32'd1);
    check("small_busy", 32'(s_busy), 32'd0);
    check("small_valid", 32'(s_dump_valid), 32'd0);
    step();
    check("small_err_clear", 32'(s_err), 32'd0);
    s_first = 5'd3; s_last = 5'd19; s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("small_accept_err", 32'(s_err), 32'd0);
    check("small_accept_busy", 32'(s_busy), 32'd1);

    // Full range with a start request mid-dump that must be ignored.
    dump_ready = 1'b1;
    do_start(5'd0, 5'd31);
    repeat (5) step();
    first = 5'd4; last = 5'd9; start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(40, 16'h0000, 0, cyc);

    // Reset after the second word of 0..7.
    dump_ready = 1'b1;
    do_start(5'd0, 5'd7);
    h0 = n_hs;
    c = 0;
    while ((n_hs - h0) < 2 && c < 10) begin
      step();
      c++;
    end
    check("two_words_seen", 32'(n_hs - h0), 32'd2);
    n_reset = 1'b0;
    step();
    check_all_zero("midreset");
    sb.delete();
    n_reset = 1'b1;
    step();
    check("post_reset_done", 32'(done), 32'd0);
    do_start(5'd5, 5'd6);
    run_until_done(10, 16'h0000, 0, cyc);
    check("fresh_cycles", 32'(cyc), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
